// File: rtl/biassram_rd_pkg.sv
// biassram_rd_pkg: shared state encoding and bias word width for the bias SRAM reader.
package biassram_rd_pkg;
   localparam int BIAS_SRAM_WLEN = 32;
   typedef enum logic [2:0] {IDLE, R1_REQ, R1_CAP, SERVE, NX_REQ, NX_CAP} state_t;
endpackage

// File: rtl/count_yi_v4.sv
// count_yi_v4: wrapping up-counter from 0 to i_final_number, with synchronous clear.
module count_yi_v4 #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_final_number,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_next
);
   logic [W-1:0] r_count;
   assign o_count = r_count;
   assign o_next  = (r_count == i_final_number) ? '0 : r_count + 1'b1;
   always_ff @(posedge clk)
      r_count <= (reset || i_clr) ? '0 : i_inc ? o_next : r_count;
endmodule

// File: rtl/biassram_rd.sv
// biassram_rd: prefetches the first bias word of a layer from the bias SRAM,
// then serves words one at a time, wrapping after the latched length.
module biassram_rd
   import biassram_rd_pkg::*;
#(
   parameter int ADDR_CNT_BITS  = 9,
   parameter int BIAS_SRAM_WLEN = biassram_rd_pkg::BIAS_SRAM_WLEN
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bias_rd1st_start,
   output logic                      bias_rd1st_busy,
   output logic                      bias_rd1st_done,
   input  logic [ADDR_CNT_BITS-1:0]  cfg_bir_lengthsub1,
   output logic                      cen_biasr_0,
   output logic                      wen_biasr_0,
   output logic [ADDR_CNT_BITS-1:0]  addr_biasr_0,
   input  logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0,
   output logic [BIAS_SRAM_WLEN-1:0] bias_data,
   output logic                      bias_valid,
   output logic                      bias_last,
   input  logic                      bias_next
);
   state_t                      r_state, w_state_nxt;
   logic                        w_start, w_adv, w_cap;
   logic [ADDR_CNT_BITS-1:0]    r_len, r_addr, w_addr, w_idx, w_idx_nxt;
   logic [BIAS_SRAM_WLEN-1:0]   r_data;
   logic                        r_valid;

   count_yi_v4 #(.W(ADDR_CNT_BITS)) u_idx (
      .clk            (clk),
      .reset          (reset),
      .i_clr          (w_start),
      .i_inc          (r_state == NX_REQ),
      .i_final_number (r_len),
      .o_count        (w_idx),
      .o_next         (w_idx_nxt)
   );

   // Start is only honoured when no read is in flight; it also pre-empts an advance.
   always_comb begin
      w_start     = bias_rd1st_start && (r_state == IDLE || r_state == SERVE);
      w_adv       = bias_next && !bias_rd1st_start && r_state == SERVE;
      w_cap       = r_state == R1_CAP || r_state == NX_CAP;
      w_state_nxt = r_state;
      w_state_nxt = w_start                ? R1_REQ :
                    r_state == R1_REQ      ? R1_CAP :
                    r_state == NX_REQ      ? NX_CAP :
                    w_cap                  ? SERVE  :
                    w_adv                  ? NX_REQ : r_state;
      w_addr      = r_state == R1_REQ ? '0 : r_state == NX_REQ ? w_idx_nxt : r_addr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr;
         if (w_start) r_len <= cfg_bir_lengthsub1;
         if (w_cap) r_data <= dout_biasr_0;
         r_valid <= (w_start || w_adv) ? 1'b0 : w_cap ? 1'b1 : r_valid;
      end
   end

   assign bias_rd1st_busy = r_state == R1_REQ || r_state == R1_CAP;
   assign bias_rd1st_done = r_state == R1_CAP;
   assign cen_biasr_0     = !(r_state == R1_REQ || r_state == NX_REQ);
   assign wen_biasr_0     = 1'b1;
   assign addr_biasr_0    = w_addr;
   assign bias_data       = r_data;
   assign bias_valid      = r_valid;
   assign bias_last       = r_valid && w_idx == r_len;
endmodule

// File: tb/tb_biassram_rd.sv
// tb_biassram_rd: randomized scenarios against a word-index model and an SRAM array model.
module tb_biassram_rd;
   localparam int AW = 9;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          next = 1'b0;
   logic [AW-1:0] cfg = '0;
   logic          busy, done, cen, wen, valid, last;
   logic [AW-1:0] addr;
   logic [DW-1:0] dout = '0;
   logic [DW-1:0] data;
   logic [DW-1:0] mem [512];
   int            rd_q[$];
   int            checks = 0;
   int            failures = 0;
   int            m_len = 0;
   int            m_idx = 0;

   biassram_rd #(.ADDR_CNT_BITS(AW), .BIAS_SRAM_WLEN(DW)) dut (
      .clk                (clk),
      .reset              (reset),
      .bias_rd1st_start   (start),
      .bias_rd1st_busy    (busy),
      .bias_rd1st_done    (done),
      .cfg_bir_lengthsub1 (cfg),
      .cen_biasr_0        (cen),
      .wen_biasr_0        (wen),
      .addr_biasr_0       (addr),
      .dout_biasr_0       (dout),
      .bias_data          (data),
      .bias_valid         (valid),
      .bias_last          (last),
      .bias_next          (next)
   );

   always #5 clk = ~clk;

   // SRAM: one-cycle read latency; every enabled cycle is logged as a read.
   always @(posedge clk)
      if (!cen) begin
         dout <= mem[addr];
         rd_q.push_back(int'(addr));
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string nm);
      checks++;
      if ({data, valid, last, busy, done, cen, wen, addr} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0}) begin
         failures++;
         $display("FAIL %s data=%h valid=%b last=%b busy=%b done=%b cen=%b wen=%b addr=%0d expected all zero with cen=1 wen=1",
                  nm, data, valid, last, busy, done, cen, wen, addr);
      end
   endtask

   task automatic do_start(input int len, input bit with_next);
      rd_q.delete();
      start = 1'b1; next = with_next; cfg = AW'(len);
      tick;
      start = 1'b0; next = 1'b0; cfg = AW'($urandom);
      checks++;
      if ({busy, done, valid} !== 3'b100) begin
         failures++;
         $display("FAIL start_t1 busy=%b done=%b valid=%b expected 1 0 0", busy, done, valid);
      end
      tick;
      checks++;
      if ({busy, done, valid} !== 3'b110) begin
         failures++;
         $display("FAIL start_t2 busy=%b done=%b valid=%b expected 1 1 0", busy, done, valid);
      end
      tick;
      m_len = len; m_idx = 0;
      checks++;
      if ({busy, done, valid} !== 3'b001 || data !== mem[0] || last !== (m_len == 0)) begin
         failures++;
         $display("FAIL start_t3 busy=%b done=%b valid=%b data=%h last=%b expected 0 0 1 %h %b",
                  busy, done, valid, data, last, mem[0], m_len == 0);
      end
      checks++;
      if (rd_q.size() != 1 || rd_q[0] != 0) begin
         failures++;
         $display("FAIL start_reads count=%0d first=%0d expected 1 read of address 0", rd_q.size(), rd_q.size() ? rd_q[0] : -1);
      end
   endtask

   task automatic do_next;
      rd_q.delete();
      next = 1'b1;
      tick;
      next = 1'b0;
      checks++;
      if (valid !== 1'b0 || last !== 1'b0) begin
         failures++;
         $display("FAIL next_t1 valid=%b last=%b expected 0 0", valid, last);
      end
      tick;
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL next_t2 valid=%b expected 0", valid);
      end
      tick;
      m_idx = (m_idx == m_len) ? 0 : m_idx + 1;
      checks++;
      if (valid !== 1'b1 || data !== mem[m_idx] || last !== (m_idx == m_len)) begin
         failures++;
         $display("FAIL next_t3 valid=%b data=%h last=%b expected 1 %h %b", valid, data, last, mem[m_idx], m_idx == m_len);
      end
      checks++;
      if (rd_q.size() != 1 || rd_q[0] != m_idx) begin
         failures++;
         $display("FAIL next_addr count=%0d addr=%0d expected 1 read of address %0d", rd_q.size(), rd_q.size() ? rd_q[0] : -1, m_idx);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) tick;
      check_reset_outputs("reset_values");
      reset = 1'b0;
      tick;
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_first;
      mem[0] = 32'hA5A5_0001;
      do_start(63, 1'b0);
      checks++;
      if (data !== 32'hA5A5_0001) begin
         failures++;
         $display("FAIL first_word data=%h expected a5a50001", data);
      end
   endtask

   task automatic test_start_held;
      int dones = 0;
      rd_q.delete();
      start = 1'b1; cfg = AW'(20);
      repeat (3) begin tick; if (done) dones++; end
      start = 1'b0;
      repeat (4) begin tick; if (done) dones++; end
      m_len = 20; m_idx = 0;
      checks++;
      if (dones != 1 || rd_q.size() != 1 || valid !== 1'b1 || busy !== 1'b0 || data !== mem[0]) begin
         failures++;
         $display("FAIL start_held dones=%0d reads=%0d valid=%b busy=%b data=%h expected 1 1 1 0 %h",
                  dones, rd_q.size(), valid, busy, data, mem[0]);
      end
   endtask

   task automatic test_wrap;
      do_start(3, 1'b0);
      repeat (5) do_next;
   endtask

   task automatic test_next_in_nx;
      rd_q.delete();
      next = 1'b1;
      tick;
      tick;
      next = 1'b0;
      repeat (4) tick;
      m_idx = (m_idx == m_len) ? 0 : m_idx + 1;
      checks++;
      if (rd_q.size() != 1 || valid !== 1'b1 || data !== mem[m_idx]) begin
         failures++;
         $display("FAIL next_in_nx reads=%0d valid=%b data=%h expected 1 1 %h", rd_q.size(), valid, data, mem[m_idx]);
      end
   endtask

   task automatic test_start_and_next;
      do_start(7, 1'b1);
      repeat (9) do_next;
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         int len = (it == 0) ? 0 : int'($urandom_range(1, 12));
         do_start(len, 1'($urandom_range(0, 1)));
         repeat (int'($urandom_range(1, 2 * len + 3))) begin
            repeat ($urandom_range(0, 2)) begin
               next = 1'($urandom_range(0, 1)) && !valid;
               tick;
               next = 1'b0;
            end
            do_next;
         end
      end
   endtask

   task automatic test_reset_mid;
      next = 1'b1;
      tick;
      next = 1'b0;
      checks++;
      if (cen !== 1'b0) begin
         failures++;
         $display("FAIL mid_read_setup cen=%b expected 0", cen);
      end
      reset = 1'b1;
      tick;
      check_reset_outputs("reset_in_nx_req");
      reset = 1'b0;
      tick;
      check_reset_outputs("idle_after_mid_reset");
      test_first;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      test_reset;
      test_first;
      test_start_held;
      test_wrap;
      test_next_in_nx;
      test_start_and_next;
      test_random;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/biassram_rd.md
BIASSRAM_RD -- requirements
Module: biassram_rd

Interface
REQ-001 Parameter ADDR_CNT_BITS, default 9, bias SRAM address width.
REQ-002 Parameter BIAS_SRAM_WLEN, default 32, bias word width.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 bias_rd1st_start  in  1  request to prefetch the first bias word of a layer.
REQ-006 bias_rd1st_busy  out  1  high from the cycle after start is accepted through the done cycle.
REQ-007 bias_rd1st_done  out  1  one-cycle pulse when word 0 is loaded into bias_data.
REQ-008 cfg_bir_lengthsub1  in  ADDR_CNT_BITS  number of bias words minus 1; sampled on start acceptance.
REQ-009 cen_biasr_0  out  1  SRAM chip enable, active-low.
REQ-010 wen_biasr_0  out  1  SRAM write enable, active-low; held 1 (read only).
REQ-011 addr_biasr_0  out  ADDR_CNT_BITS  SRAM read address.
REQ-012 dout_biasr_0  in  BIAS_SRAM_WLEN  SRAM read data, valid 1 cycle after a cen_biasr_0=0 cycle.
REQ-013 bias_data  out  BIAS_SRAM_WLEN  current bias word to the compute array.
REQ-014 bias_valid  out  1  bias_data holds a valid word.
REQ-015 bias_last  out  1  bias_valid is high and the current word index equals the sampled length-1.
REQ-016 bias_next  in  1  consumer pulse: advance to the next bias word.

Function
REQ-017 States: IDLE, R1_REQ, R1_CAP, SERVE, NX_REQ, NX_CAP.
REQ-018 IDLE or SERVE with bias_rd1st_start=1 -> R1_REQ; latch cfg_bir_lengthsub1; index reset to 0; bias_valid cleared.
REQ-019 bias_rd1st_start in any other state is ignored, including a start held high for extra cycles.
REQ-020 R1_REQ: cen_biasr_0=0, addr=0; next state R1_CAP.
REQ-021 R1_CAP: bias_data<=dout_biasr_0, bias_valid<=1, bias_rd1st_done=1 for this cycle only; next state SERVE.
REQ-022 bias_rd1st_busy=1 exactly in R1_REQ and R1_CAP; start sampled at cycle T gives busy at T+1 and T+2, done at T+2, bias_valid=1 at T+3.
REQ-023 SERVE with bias_next=1 and no start: bias_valid<=0; next state NX_REQ.
REQ-024 NX_REQ: cen=0, addr = index+1, or 0 when index == latched lengthsub1 (wrap); index updated to the issued address.
REQ-025 NX_CAP: capture dout_biasr_0 into bias_data, bias_valid<=1; next state SERVE.
REQ-026 Advance latency: bias_next sampled at cycle T gives bias_valid=0 at T+1 and T+2, and the new word with valid=1 at T+3.
REQ-027 bias_next while bias_valid=0 (R1_*, NX_*, IDLE) is ignored and not queued.
REQ-028 Simultaneous start and bias_next in SERVE: start wins; bias_next is dropped.
REQ-029 lengthsub1=0: every advance re-reads address 0; bias_last is permanently high while valid.
REQ-030 cen_biasr_0=1 in every state except R1_REQ and NX_REQ; addr_biasr_0 holds its last value when cen=1.
REQ-031 Index arithmetic is unsigned ADDR_CNT_BITS wide; the wrap compare uses the latched length, never the live cfg input.

Reset
REQ-032 Reset applies in any state, including mid-read: state=IDLE, index=0, latched length=0.
REQ-033 Output reset values: bias_data=0, bias_valid=0, bias_last=0, bias_rd1st_busy=0, bias_rd1st_done=0, cen=1, wen=1, addr=0.
REQ-034 An SRAM read in flight at reset is discarded.

Structure
REQ-035 The shared package holds the state encoding (3-bit enum) and BIAS_SRAM_WLEN.
REQ-036 The wrapping word-index counter is a single sub-module instance of count_yi_v4, with final_number = latched lengthsub1.

Verification
REQ-037 Reset, then start pulse with lengthsub1=63 and SRAM[0]=0xA5A5_0001 -> busy at T+1..T+2, done at T+2 only, bias_data=0xA5A5_0001 with valid at T+3.
REQ-038 Start held high for 3 cycles -> exactly one R1 read, one done pulse, and no second prefetch.
REQ-039 lengthsub1=3, 5 bias_next pulses -> addresses 1,2,3,0,1; bias_last high only while word 3 is presented.
REQ-040 bias_next pulsed during NX_REQ -> ignored; exactly one advance occurs.
REQ-041 Start and bias_next in the same SERVE cycle with new lengthsub1=7 -> read address 0, done pulse, and subsequent wrap at 7.
REQ-042 Reset asserted in NX_REQ -> next cycle all outputs at reset values; the following start behaves exactly as in REQ-037.
